// File: rtl/core_inst_seq_pkg.sv
// Shared definitions for the core instruction sequencer: inst word bit map, NOP word, FSM states.
// The optional pause input is enabled by defining CORE_SEQ_PAUSE_EN.
package core_inst_pkg;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    localparam int ACC_BIT      = 33;
    localparam int CEN_PMEM_BIT = 32;
    localparam int WEN_PMEM_BIT = 31;
    localparam int A_PMEM_MSB   = 30;
    localparam int A_PMEM_LSB   = 20;
    localparam int CEN_XMEM_BIT = 19;
    localparam int WEN_XMEM_BIT = 18;
    localparam int A_XMEM_MSB   = 17;
    localparam int A_XMEM_LSB   = 7;
    localparam int OFIFO_RD_BIT = 6;
    localparam int IFIFO_WR_BIT = 5;
    localparam int IFIFO_RD_BIT = 4;
    localparam int L0_RD_BIT    = 3;
    localparam int L0_WR_BIT    = 2;
    localparam int EXECUTE_BIT  = 1;
    localparam int LOAD_BIT     = 0;

    // Memory enables are active-low, so an idle word keeps both memories deselected.
    localparam logic [INST_W-1:0] NOP = (INST_W'(1) << CEN_PMEM_BIT) | (INST_W'(1) << WEN_PMEM_BIT)
                                      | (INST_W'(1) << CEN_XMEM_BIT) | (INST_W'(1) << WEN_XMEM_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WL0,
        S_WPE,
        S_XL0,
        S_EXE,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// The core's instruction interface: the sequencer drives inst, the core reports OFIFO occupancy on valid.
interface core_inst_seq_if;
    import core_inst_pkg::*;

    // valid = core OFIFO holds at least one word; the sequencer consumes a word by raising
    // ofifo_rd in inst. There is no back-pressure toward the sequencer on inst itself.
    logic [INST_W-1:0] inst;
    logic              valid;

    modport master (output inst, input valid);
    modport slave  (input inst, output valid);

endinterface

// File: rtl/core_seq_l0_loader.sv
// Read-then-write helper for WL0/XL0: issues count xmem reads from base and the matching
// l0_wr one cycle after each read; a write already in flight completes even while held.
module core_seq_l0_loader
    import core_inst_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              hold,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              wr,
    output logic              last
);

    logic [CNT_W-1:0] rd_cnt;
    logic             pend_q;

    assign rd   = go && !hold && (rd_cnt < count);
    assign wr   = go && pend_q;
    assign last = go && pend_q && (rd_cnt == count);
    assign addr = base + ADDR_W'(rd_cnt);

    always_ff @(posedge clk) begin
        if (reset || !go || last) begin
            rd_cnt <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= rd;
            rd_cnt <= rd_cnt + CNT_W'(rd);
        end
    end

endmodule

// File: rtl/core_inst_seq.sv
// Weight-stationary tile sequencer: per kij runs WL0, WPE, XL0, EXE, OUT and issues one
// registered inst word per cycle. Define CORE_SEQ_PAUSE_EN to add the pause input.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int drain   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef CORE_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    core_inst_seq_if.master   core,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    // A too-short drain would let the next burst overlap data still moving through the array.
    localparam int SETTLE = (drain < row + col) ? row + col : drain;
    localparam int PH_W   = $clog2(len_nij + col + SETTLE + 1);
    localparam int NIJ_W  = $clog2(len_nij + 1);
    localparam int KIJ_W  = $clog2(len_kij + 1);

    localparam logic [PH_W-1:0]  COL_N     = PH_W'(col);
    localparam logic [PH_W-1:0]  NIJ_N     = PH_W'(len_nij);
    localparam logic [PH_W-1:0]  WPE_END   = PH_W'(col + SETTLE - 1);
    localparam logic [PH_W-1:0]  EXE_END   = PH_W'(len_nij + SETTLE - 1);
    localparam logic [NIJ_W-1:0] OUT_N     = NIJ_W'(len_nij);
    localparam logic [NIJ_W-1:0] OUT_LAST  = NIJ_W'(len_nij - 1);

    state_t            state, state_next;
    logic [INST_W-1:0] inst_q, inst_next;
    logic [KIJ_W-1:0]  kij;
    logic [PH_W-1:0]   ph_cnt;
    logic [NIJ_W-1:0]  rd_cnt, wr_cnt;
    logic              out_pend;
    logic              hold;

`ifdef CORE_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    logic              ld_go, ld_rd, ld_wr, ld_last;
    logic [ADDR_W-1:0] ld_base, ld_addr;
    logic [PH_W-1:0]   ld_count;
    logic [ADDR_W-1:0] w_blk, p_addr;

    assign w_blk    = w_base + ADDR_W'(int'(kij) * col);
    assign ld_go    = (state == S_WL0) || (state == S_XL0);
    assign ld_base  = (state == S_WL0) ? w_blk : x_base;
    assign ld_count = (state == S_WL0) ? COL_N : NIJ_N;

    core_seq_l0_loader #(.CNT_W(PH_W)) u_loader (
        .clk   (clk),
        .reset (reset),
        .go    (ld_go),
        .hold  (hold),
        .base  (ld_base),
        .count (ld_count),
        .addr  (ld_addr),
        .rd    (ld_rd),
        .wr    (ld_wr),
        .last  (ld_last)
    );

    // OUT: ofifo_rd when valid, then the pmem write one cycle later from out_pend.
    logic out_rd, out_wr, out_last;

    assign out_rd   = (state == S_OUT) && core.valid && !hold && (rd_cnt < OUT_N);
    assign out_wr   = (state == S_OUT) && out_pend;
    assign out_last = out_wr && (wr_cnt == OUT_LAST);
    assign p_addr   = p_base + ADDR_W'(int'(kij) * len_nij) + ADDR_W'(wr_cnt);

    always_comb begin
        state_next = state;
        inst_next  = NOP;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_WL0;
            end
            S_WL0, S_XL0: begin
                if (ld_rd) begin
                    inst_next[CEN_XMEM_BIT]            = 1'b0;
                    inst_next[A_XMEM_MSB:A_XMEM_LSB]   = ld_addr;
                end
                inst_next[L0_WR_BIT] = ld_wr;
                if (ld_last) state_next = (state == S_WL0) ? S_WPE : S_EXE;
            end
            S_WPE: begin
                if (ph_cnt < COL_N) begin
                    inst_next[L0_RD_BIT] = 1'b1;
                    inst_next[LOAD_BIT]  = 1'b1;
                end
                if (ph_cnt == WPE_END) state_next = S_XL0;
            end
            S_EXE: begin
                if (ph_cnt < NIJ_N) begin
                    inst_next[L0_RD_BIT]   = 1'b1;
                    inst_next[EXECUTE_BIT] = 1'b1;
                end
                if (ph_cnt == EXE_END) state_next = S_OUT;
            end
            S_OUT: begin
                inst_next[OFIFO_RD_BIT] = out_rd;
                if (out_wr) begin
                    inst_next[CEN_PMEM_BIT]          = 1'b0;
                    inst_next[WEN_PMEM_BIT]          = 1'b0;
                    inst_next[A_PMEM_MSB:A_PMEM_LSB] = p_addr;
                end
                if (out_last) state_next = (int'(kij) + 1 < len_kij) ? S_WL0 : S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            inst_q   <= NOP;
            kij      <= '0;
            ph_cnt   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            out_pend <= 1'b0;
        end else begin
            state  <= state_next;
            inst_q <= inst_next;

            if ((state == S_WPE || state == S_EXE) && state_next == state)
                ph_cnt <= ph_cnt + PH_W'(1);
            else
                ph_cnt <= '0;

            if (state == S_OUT && !out_last) begin
                out_pend <= out_rd;
                rd_cnt   <= rd_cnt + NIJ_W'(out_rd);
                wr_cnt   <= wr_cnt + NIJ_W'(out_wr);
            end else begin
                out_pend <= 1'b0;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
            end

            if (out_last)
                kij <= kij + KIJ_W'(1);
            else if (state == S_DONE)
                kij <= '0;
        end
    end

    assign core.inst = inst_q;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule
